// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the bram_device block: request function codes,
// transfer size codes, the response record and the latency-pipeline metadata.
// -----------------------------------------------------------------------------
package bram_pkg;

    // Request function (in_req_bits_func)
    localparam logic FUNC_READ  = 1'b0;
    localparam logic FUNC_WRITE = 1'b1;

    // Transfer size codes (in_req_bits_len): access is 2^len bytes
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;
    localparam logic [1:0] LEN_8B = 2'd3;

    // Response data is carried at the widest legal DATA_W; narrower
    // configurations zero-extend on entry and truncate on exit.
    localparam int RESP_DATA_W = 64;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic                   err;
    } resp_t;

    // Control travelling alongside a request through the latency pipeline.
    // 'zero' forces the response data to 0 (writes and erroneous requests).
    typedef struct packed {
        logic valid;
        logic err;
        logic zero;
    } pipe_meta_t;

    // True when the low address bits are not aligned to a 2^len access.
    function automatic logic len_misaligned(input logic [2:0] addr_lo,
                                            input logic [1:0] len);
        case (len)
            LEN_1B:  return 1'b0;
            LEN_2B:  return addr_lo[0];
            LEN_4B:  return |addr_lo[1:0];
            default: return |addr_lo[2:0];
        endcase
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Synchronous first-word-fall-through FIFO used to hold completed responses
// while the response port is stalled.
//   clock, reset : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full)
//   pop             : discard the head entry (ignored when empty)
//   pop_data        : current head entry, valid whenever !empty
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic do_push;
    logic do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = storage[rd_ptr];

    // NOTE: storage arrays carry no reset; only the pointers and count decide
    // which entries are meaningful, and a reset-free array maps onto RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bram_device.sv
// -----------------------------------------------------------------------------
// bram_device
// Block-RAM backed memory slave with a valid/ready request port and an
// in-order valid/ready response port. Writes commit in the accept cycle;
// every request gets exactly one response LATENCY cycles later (or later if
// the response port is stalled, in which case responses queue in resp_fifo).
//   clock                 : sole clock, rising edge
//   reset                 : asynchronous reset, active-low
//   in_req_valid/ready    : request handshake
//   in_req_bits_addr      : byte address
//   in_req_bits_len       : size code, 2^len bytes
//   in_req_bits_data/strb : write data and byte enables
//   in_req_bits_func      : 0 read, 1 write
//   in_resp_valid/ready   : response handshake
//   in_resp_bits_data/err : read data (0 for writes/errors), error flag
// -----------------------------------------------------------------------------
module bram_device
    import bram_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2,
    parameter int          RESP_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_req_valid,
    output logic                in_req_ready,
    input  logic [31:0]         in_req_bits_addr,
    input  logic [1:0]          in_req_bits_len,
    input  logic [DATA_W-1:0]   in_req_bits_data,
    input  logic                in_req_bits_func,
    input  logic [DATA_W/8-1:0] in_req_bits_strb,
    output logic                in_resp_valid,
    input  logic                in_resp_ready,
    output logic [DATA_W-1:0]   in_resp_bits_data,
    output logic                in_resp_bits_err
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          OFF_W     = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam int          CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS * BYTES);

    // ---------------- request decode ----------------
    logic             accept;
    logic [32:0]      offset;
    logic             req_err;
    logic [IDX_W-1:0] idx;

    assign accept = in_req_valid && in_req_ready;

    // One extra bit so an address below BASE_ADDR wraps to a huge offset and
    // fails the same range compare as one above the top.
    assign offset  = {1'b0, in_req_bits_addr} - {1'b0, BASE_ADDR};
    assign req_err = (offset >= MEM_BYTES)
                  || (in_req_bits_len > 2'(OFF_W))
                  || len_misaligned(in_req_bits_addr[2:0], in_req_bits_len);
    assign idx     = offset[OFF_W +: IDX_W];

    // ---------------- memory and read-data pipeline ----------------
    logic [DATA_W-1:0] mem       [MEM_WORDS];
    logic [DATA_W-1:0] pipe_data [LATENCY];
    pipe_meta_t        pipe_meta [LATENCY];

    // Read data is captured in the accept cycle, before any same-cycle write
    // lands; only one request is accepted per cycle, so every earlier write
    // is already in the array.
    always_ff @(posedge clock) begin
        if (accept && (in_req_bits_func == FUNC_WRITE) && !req_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (in_req_bits_strb[b]) begin
                    mem[idx][b*8 +: 8] <= in_req_bits_data[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            pipe_data[0] <= mem[idx];
        end
        for (int k = 1; k < LATENCY; k++) begin
            pipe_data[k] <= pipe_data[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe_meta[k] <= '0;
            end
        end else begin
            pipe_meta[0].valid <= accept;
            pipe_meta[0].err   <= req_err;
            pipe_meta[0].zero  <= req_err || (in_req_bits_func == FUNC_WRITE);
            for (int k = 1; k < LATENCY; k++) begin
                pipe_meta[k] <= pipe_meta[k-1];
            end
        end
    end

    // ---------------- response path ----------------
    resp_t last_resp;
    resp_t fifo_head;
    resp_t out_resp;
    logic  last_valid;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_push;
    logic  fifo_pop;
    logic  resp_valid;
    logic  handoff;

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it holding state (a latch).
    always_comb begin
        last_resp      = '0;
        last_resp.err  = pipe_meta[LATENCY-1].err;
        if (!pipe_meta[LATENCY-1].zero) begin
            last_resp.data = RESP_DATA_W'(pipe_data[LATENCY-1]);
        end
    end

    assign last_valid = pipe_meta[LATENCY-1].valid;

    // The FIFO is bypassed when empty so an unstalled response appears the
    // cycle it leaves the pipeline; otherwise it queues behind older ones.
    assign resp_valid = !fifo_empty || last_valid;
    assign out_resp   = fifo_empty ? last_resp : fifo_head;
    assign handoff    = resp_valid && in_resp_ready;
    assign fifo_push  = last_valid && !fifo_full && !(fifo_empty && in_resp_ready);
    assign fifo_pop   = handoff && !fifo_empty;

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH ($bits(resp_t))
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (last_resp),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_resp_valid     = resp_valid;
    assign in_resp_bits_data = resp_valid ? DATA_W'(out_resp.data) : '0;
    assign in_resp_bits_err  = resp_valid && out_resp.err;

    // ---------------- outstanding count ----------------
    logic [CNT_W-1:0] outstanding;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else if (accept && !handoff) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!accept && handoff) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // Ready depends only on the registered count (never on in_resp_ready) and
    // is forced low while reset is held; 'reset' is active-low.
    assign in_req_ready = reset && (outstanding < CNT_W'(RESP_DEPTH));

endmodule

// File: doc/bram_device.md
BRAM_DEVICE -- requirements
Module: bram_device

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter MEM_WORDS, default 4096, meaning memory depth in DATA_W words; must be a power of 2.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0; aligned to MEM_WORDS*DATA_W/8.
REQ-004 SHALL have parameter LATENCY, default 2, meaning accept-to-response cycles; legal range 1..4.
REQ-005 SHALL have parameter RESP_DEPTH, default 4, meaning maximum outstanding requests; power of 2 and >= LATENCY.
REQ-006 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-007 SHALL have ports: reset  in  1  asynchronous reset, active-low.
REQ-008 SHALL have ports: in_req_valid in 1 request valid; in_req_ready out 1 request accepted this cycle if valid.
REQ-009 SHALL have ports: in_req_bits_addr in 32 byte address; in_req_bits_len in 2 size code, 2^len bytes.
REQ-010 SHALL have ports: in_req_bits_data in DATA_W write data; in_req_bits_func in 1 (0 read, 1 write); in_req_bits_strb in DATA_W/8 byte enables.
REQ-011 SHALL have ports: in_resp_valid out 1; in_resp_ready in 1; in_resp_bits_data out DATA_W; in_resp_bits_err out 1 error flag.

Function
REQ-012 Request SHALL be accepted on cycles where in_req_valid and in_req_ready are both 1 ("accept").
REQ-013 in_req_ready SHALL be 1 iff outstanding count < RESP_DEPTH; outstanding = accepted minus responses handed off.
REQ-014 Outstanding count SHALL +1 on accept only, -1 on response handoff only, and stay unchanged when both occur.
REQ-015 Error SHALL be flagged when: address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*DATA_W/8), 2^len > DATA_W/8, or address not aligned to 2^len.
REQ-016 Word index SHALL be (addr-BASE_ADDR) >> log2(DATA_W/8); lower address bits SHALL be ignored for indexing.
REQ-017 A valid write SHALL update, in the accept cycle, exactly the bytes whose strb bit is 1; strb=0 SHALL be a legal no-op write.
REQ-018 An erroneous write SHALL NOT modify memory.
REQ-019 A read SHALL return the full word as stored after all earlier-accepted writes, unshifted; an erroneous read SHALL return 0.
REQ-020 Every accepted request, including each write, SHALL produce exactly one response; a write response SHALL carry data 0.
REQ-021 Responses SHALL be delivered strictly in accept order.
REQ-022 With no backpressure, in_resp_valid SHALL rise exactly LATENCY cycles after accept.
REQ-023 Once in_resp_valid is high, it and its payload SHALL hold until in_resp_ready is 1 ("handoff").
REQ-024 Responses completing while the output is stalled SHALL be buffered; no response SHALL ever be dropped, because REQ-013 bounds occupancy.
REQ-025 Back-to-back accepts SHALL sustain one request per cycle when in_resp_ready is held at 1.
REQ-026 Handoff and a new accept in the same cycle at full occupancy SHALL NOT be allowed: ready is computed from registered count, not combinationally from in_resp_ready.

Reset
REQ-027 While reset is 0: in_req_ready=0, in_resp_valid=0, in_resp_bits_data=0, in_resp_bits_err=0.
REQ-028 Reset SHALL clear the latency pipeline, response buffer, and outstanding count; in-flight requests SHALL be discarded without response.
REQ-029 Memory contents SHALL NOT be affected by reset; writes accepted before reset remain visible.
REQ-030 in_req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-031 Shared package bram_pkg SHALL hold FUNC_READ/FUNC_WRITE constants, LEN_* size codes, and the response record type (data, err).
REQ-032 Response buffering SHALL be a sub-module resp_fifo: synchronous, parametrised depth/width, with push/pop/full/empty.
REQ-033 Memory SHALL be a single synchronous-write array with byte-lane writes, inferable as block RAM.

Verification
REQ-034 Defaults: write addr 0x10, data 0xDEADBEEF, strb 4'b1111; read 0x10 -> resp after 2 cycles, data 0xDEADBEEF, err 0.
REQ-035 Byte-lane write: strb 4'b0010, data 0x0000AA00 to 0x10, then read -> 0xDEADAAEF.
REQ-036 Error cases: read 0x4000 (out of range), read 0x11 len=2 (misaligned), len=3 with DATA_W=32 -> each err=1, data 0; memory unchanged.
REQ-037 Backpressure: hold in_resp_ready=0 and issue 6 reads -> exactly 4 accepted, ready=0; release -> 4 responses in order, then ready=1.
REQ-038 Reset mid-burst: 3 reads in flight, pulse reset low -> no responses emitted; prior write at 0x10 still reads 0xDEADBEEF.
